// File: rtl/min_trigger_gen.sv
// Threshold trigger: delays the ADC stream PRE_ACQUI_LEN+2 beats, opens a START_TRG window on a crossing.
// Latency PRE_ACQUI_LEN+2 cycles data-path; no backpressure: always ready, a trigger while FIFO_FULL is dropped and counted.
module min_trigger_gen #(
  parameter int THRESHOLD            = 10,
  parameter int PRE_ACQUI_LEN        = 12,
  parameter int POST_ACQUI_LEN       = 38,
  parameter int TIME_STAMP_WIDTH     = 16,
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int S_AXIS_TDATA_WIDTH   = 128
) (
  input  logic                          AXIS_ACLK,
  input  logic                          AXIS_ARESET,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                          S_AXIS_TVALID,
  output logic                          S_AXIS_TREADY,
  output logic [S_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                          M_AXIS_TVALID,
  output logic                          START_TRG,
  output logic [TIME_STAMP_WIDTH-1:0]   TIME_STAMP,
  input  logic                          FIFO_FULL,
  input  logic                          TRG_ENABLE,
  output logic [15:0]                   DROP_CNT
);

  localparam int LANES   = S_AXIS_TDATA_WIDTH / 16;
  localparam int DLY     = PRE_ACQUI_LEN + 2;
  localparam int WIN     = PRE_ACQUI_LEN + POST_ACQUI_LEN;
  localparam int THR_VAL = (THRESHOLD * (1 << (ADC_RESOLUTION_WIDTH - 1))) / 100;
  localparam int FW      = (DLY > 1) ? $clog2(DLY) : 1;
  localparam int WW      = $clog2(WIN + 1);
  localparam int ADW     = ADC_RESOLUTION_WIDTH;

  typedef enum logic [1:0] {FILL, HOLDOFF, ARMED, ACQ} state_t;

  state_t                        state_q;
  logic [FW-1:0]                 fill_cnt_q;
  logic [WW-1:0]                 win_cnt_q;
  logic                          trg_q;
  logic [TIME_STAMP_WIDTH-1:0]   ts_out_q;
  logic [15:0]                   drop_cnt_q;
  logic [TIME_STAMP_WIDTH-1:0]   ts_cnt_q;
  logic [TIME_STAMP_WIDTH-1:0]   ts_hit_q;
  logic                          hit_d;
  logic                          hit_q;
  logic                          tready_q;
  logic [S_AXIS_TDATA_WIDTH:0]   dly_q [DLY];

  // Sample sits in the top ADW bits of each 16-bit lane; signed strict compare.
  always_comb begin
    hit_d = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (int'($signed(S_AXIS_TDATA[16*i+16-ADW +: ADW])) > THR_VAL) hit_d = 1'b1;
    end
    hit_d = hit_d & S_AXIS_TVALID;
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      for (int i = 0; i < DLY; i++) dly_q[i] <= '0;
      tready_q <= 1'b0;
      ts_cnt_q <= '0;
      ts_hit_q <= '0;
      hit_q    <= 1'b0;
    end else begin
      dly_q[0] <= {S_AXIS_TVALID, S_AXIS_TDATA};
      for (int i = 1; i < DLY; i++) dly_q[i] <= dly_q[i-1];
      tready_q <= 1'b1;
      ts_cnt_q <= ts_cnt_q + 1'b1;
      ts_hit_q <= ts_cnt_q;
      hit_q    <= hit_d;
    end
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
      win_cnt_q  <= '0;
      trg_q      <= 1'b0;
      ts_out_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (fill_cnt_q == FW'(DLY - 1)) state_q <= HOLDOFF;
          else                            fill_cnt_q <= fill_cnt_q + 1'b1;
        end
        // Re-arming needs a quiet cycle so a held level yields one window.
        HOLDOFF: begin
          if (!hit_q) state_q <= ARMED;
        end
        ARMED: begin
          if (hit_q && TRG_ENABLE) begin
            if (!FIFO_FULL) begin
              state_q   <= ACQ;
              trg_q     <= 1'b1;
              ts_out_q  <= ts_hit_q;
              win_cnt_q <= WW'(WIN);
            end else begin
              state_q <= HOLDOFF;
              if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 1'b1;
            end
          end
        end
        ACQ: begin
          if (win_cnt_q == WW'(1)) begin
            state_q <= HOLDOFF;
            trg_q   <= 1'b0;
          end else begin
            win_cnt_q <= win_cnt_q - 1'b1;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign S_AXIS_TREADY = tready_q;
  assign M_AXIS_TVALID = dly_q[DLY-1][S_AXIS_TDATA_WIDTH];
  assign M_AXIS_TDATA  = dly_q[DLY-1][S_AXIS_TDATA_WIDTH-1:0];
  assign START_TRG     = trg_q;
  assign TIME_STAMP    = ts_out_q;
  assign DROP_CNT      = drop_cnt_q;

endmodule

// File: tb/tb_min_trigger_gen.sv
// Directed bench for min_trigger_gen: cycle k = k rising edges after reset release.
module tb_min_trigger_gen;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] s_tdata;
  logic         s_tvalid;
  logic         s_tready;
  logic [127:0] m_tdata;
  logic         m_tvalid;
  logic         start_trg;
  logic [15:0]  time_stamp;
  logic         fifo_full;
  logic         trg_en;
  logic [15:0]  drop_cnt;

  int   cyc, trg_hi, trg_rise, passed, failed, total;
  logic trg_prev;
  logic [127:0] marker;

  min_trigger_gen dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESET  (rst),
    .S_AXIS_TDATA (s_tdata),
    .S_AXIS_TVALID(s_tvalid),
    .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA (m_tdata),
    .M_AXIS_TVALID(m_tvalid),
    .START_TRG    (start_trg),
    .TIME_STAMP   (time_stamp),
    .FIFO_FULL    (fifo_full),
    .TRG_ENABLE   (trg_en),
    .DROP_CNT     (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] word(input int lane, input logic [11:0] s);
    logic [127:0] w;
    w = '0;
    w[16*lane +: 16] = {s, 4'h0};
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (start_trg === 1'b1) trg_hi++;
    if (start_trg === 1'b1 && trg_prev !== 1'b1) trg_rise++;
    trg_prev = start_trg;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clr();
    trg_hi   = 0;
    trg_rise = 0;
    trg_prev = start_trg;
  endtask

  task automatic shot(input logic [11:0] s, input logic v);
    s_tdata  = word(5, s);
    s_tvalid = v;
    tick();
    s_tdata  = '0;
    s_tvalid = 1'b1;
  endtask

  task automatic thr(input string tag, input logic [11:0] s, input logic v, input int exp);
    clr();
    shot(s, v);
    run(60);
    chk(tag, 128'(trg_hi), 128'(exp));
  endtask

  initial begin
    passed = 0; failed = 0; total = 0; cyc = 0;
    rst = 1'b1; s_tdata = '0; s_tvalid = 1'b1; fifo_full = 1'b0; trg_en = 1'b1;
    clr();
    repeat (3) @(negedge clk);
    chk("rst_start_trg", 128'(start_trg), 0);
    chk("rst_time_stamp", 128'(time_stamp), 0);
    chk("rst_drop_cnt", 128'(drop_cnt), 0);
    chk("rst_tready", 128'(s_tready), 0);
    chk("rst_m_tvalid", 128'(m_tvalid), 0);
    chk("rst_m_tdata", m_tdata, 0);

    rst = 1'b0; cyc = 0; clr();
    chk("tready_c0", 128'(s_tready), 0);
    tick();
    chk("tready_c1", 128'(s_tready), 1);

    // Hit during fill is ignored; marker at 88 must emerge at 102.
    run(5 - cyc);
    s_tdata = word(3, 12'd300);
    tick();
    s_tdata = '0;
    run(88 - cyc);
    marker  = word(2, 12'hB2E) | 128'h5;
    s_tdata = marker;
    tick();
    s_tdata = '0;
    run(100 - cyc);
    chk("fill_hit_ignored", 128'(trg_hi), 0);
    clr();
    s_tdata = word(3, 12'd300);
    tick();
    s_tdata = '0;
    chk("trg_c101", 128'(start_trg), 0);
    chk("mdata_c101", m_tdata, 0);
    tick();
    chk("trg_c102", 128'(start_trg), 1);
    chk("ts_c102", 128'(time_stamp), 100);
    chk("mdata_c102", m_tdata, marker);
    chk("mvalid_c102", 128'(m_tvalid), 1);
    run(151 - cyc);
    chk("trg_c151", 128'(start_trg), 1);
    tick();
    chk("trg_c152", 128'(start_trg), 0);
    chk("win_len", 128'(trg_hi), 50);

    thr("thr_204", 12'd204, 1'b1, 0);
    thr("thr_205", 12'd205, 1'b1, 50);
    thr("thr_neg300", 12'hED4, 1'b1, 0);
    thr("thr_tvalid0", 12'd300, 1'b0, 0);

    // Held level gives one window; quiet cycle then hit gives a second.
    clr();
    s_tdata = word(5, 12'd300);
    run(80);
    chk("sustain_len", 128'(trg_hi), 50);
    chk("sustain_rises", 128'(trg_rise), 1);
    s_tdata = '0;
    tick();
    s_tdata = word(5, 12'd300);
    tick();
    s_tdata = '0;
    run(60);
    chk("second_len", 128'(trg_hi), 100);
    chk("second_rises", 128'(trg_rise), 2);

    fifo_full = 1'b1;
    clr();
    shot(12'd300, 1'b1);
    run(5);
    chk("drop_no_trg", 128'(trg_hi), 0);
    chk("drop_cnt_1", 128'(drop_cnt), 1);
    fifo_full = 1'b0;
    run(3);

    force dut.drop_cnt_q = 16'hFFFF;
    tick();
    release dut.drop_cnt_q;
    chk("drop_preload", 128'(drop_cnt), 16'hFFFF);
    fifo_full = 1'b1;
    clr();
    shot(12'd300, 1'b1);
    run(5);
    chk("drop_sat", 128'(drop_cnt), 16'hFFFF);
    chk("drop_sat_no_trg", 128'(trg_hi), 0);
    fifo_full = 1'b0;
    run(3);

    clr();
    shot(12'd300, 1'b1);
    run(10);
    fifo_full = 1'b1;
    run(60);
    chk("full_midwin_len", 128'(trg_hi), 50);
    chk("full_midwin_drop", 128'(drop_cnt), 16'hFFFF);
    fifo_full = 1'b0;
    run(3);

    trg_en = 1'b0;
    clr();
    shot(12'd300, 1'b1);
    run(5);
    trg_en = 1'b1;
    run(60);
    chk("disabled_hit", 128'(trg_hi), 0);

    // Crossing exactly at the wrap point of the timestamp counter.
    while (cyc < 65535) tick();
    chk("ts_cnt_max", 128'(dut.ts_cnt_q), 16'hFFFF);
    clr();
    shot(12'd300, 1'b1);
    chk("ts_cnt_wrap", 128'(dut.ts_cnt_q), 0);
    tick();
    chk("wrap_trg", 128'(start_trg), 1);
    chk("wrap_ts", 128'(time_stamp), 16'hFFFF);
    run(60);
    while (cyc < 65600) tick();
    shot(12'd300, 1'b1);
    tick();
    chk("post_wrap_ts", 128'(time_stamp), 64);
    run(19);
    chk("pre_rst_trg", 128'(start_trg), 1);

    rst = 1'b1;
    #1;
    chk("midwin_rst_trg", 128'(start_trg), 0);
    chk("midwin_rst_ts", 128'(time_stamp), 0);
    chk("midwin_rst_drop", 128'(drop_cnt), 0);
    chk("midwin_rst_mvalid", 128'(m_tvalid), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; cyc = 0; clr();
    run(5);
    shot(12'd300, 1'b1);
    run(60);
    chk("refill_hit_ignored", 128'(trg_hi), 0);
    while (cyc < 70) tick();
    shot(12'd300, 1'b1);
    tick();
    chk("rearm_trg", 128'(start_trg), 1);
    chk("rearm_ts", 128'(time_stamp), 70);
    run(60);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/min_trigger_gen.md
# min_trigger_gen

Threshold trigger generator that sits directly upstream of the acquisition/packetising stage in the minimum-trigger chain. It watches the RF Data Converter sample stream and delays that stream by a fixed pre-acquisition depth. On a threshold crossing it asserts START_TRG for one acquisition window, aligned so the window contains PRE_ACQUI_LEN beats before the crossing. It also latches the crossing's TIME_STAMP. The downstream stage consumes M_AXIS_TDATA, START_TRG and TIME_STAMP and returns its FIFO full flag.

## Interface
- THRESHOLD, 10: trigger level in percent (0..100) of positive full scale; THR_VAL = (THRESHOLD * 2^(ADC_RESOLUTION_WIDTH-1)) / 100, truncated (default 204).
- PRE_ACQUI_LEN, 12: beats captured before the crossing beat.
- POST_ACQUI_LEN, 38: beats captured from the crossing beat onward.
- TIME_STAMP_WIDTH, 16: timestamp counter width.
- ADC_RESOLUTION_WIDTH, 12: sample resolution.
- S_AXIS_TDATA_WIDTH, 128: stream width, 16-bit lanes (8 lanes at default).
- AXIS_ACLK  in  1  single clock; all logic is on the rising edge.
- AXIS_ARESET  in  1  asynchronous, active-high reset.
- S_AXIS_TDATA  in  S_AXIS_TDATA_WIDTH  ADC beat; lane i = bits [16i+15:16i]; sample = lane[15:4], signed two's complement.
- S_AXIS_TVALID  in  1  beat valid.
- S_AXIS_TREADY  out  1  registered; 0 in reset, 1 from the first edge after reset release.
- M_AXIS_TDATA  out  S_AXIS_TDATA_WIDTH  input data delayed PRE_ACQUI_LEN+2 cycles.
- M_AXIS_TVALID  out  1  S_AXIS_TVALID delayed identically.
- START_TRG  out  1  high for the acquisition window.
- TIME_STAMP  out  TIME_STAMP_WIDTH  counter value at the crossing cycle; held until the next trigger.
- FIFO_FULL  in  1  downstream FIFO full flag.
- TRG_ENABLE  in  1  arms triggering when 1.
- DROP_CNT  out  16  saturating count of triggers dropped because FIFO_FULL was high.

## Operation
- Delay line: PRE_ACQUI_LEN+2 registered stages of {TVALID, TDATA}.
  - Shifts every clock, independent of TVALID.
  - M_AXIS_*(t) = S_AXIS_*(t-PRE_ACQUI_LEN-2).
- Comparator: hit(t) = S_AXIS_TVALID & (any lane sample > THR_VAL), signed strict greater-than. Registered once as hit_r.
- Timestamp counter: free-running, increments every clock, wraps 2^TIME_STAMP_WIDTH-1 -> 0. The counter value at cycle t is pipelined alongside hit.
- FSM states: FILL, HOLDOFF, ARMED, ACQ.
  - FILL: entered on reset. Counts PRE_ACQUI_LEN+2 cycles, then goes to HOLDOFF. Hits are ignored.
  - HOLDOFF: goes to ARMED on the first cycle with hit_r=0.
  - ARMED with hit_r=1, TRG_ENABLE=1, FIFO_FULL=0: go to ACQ, latch TIME_STAMP, load the window counter with PRE_ACQUI_LEN+POST_ACQUI_LEN.
  - ARMED with hit_r=1, TRG_ENABLE=1, FIFO_FULL=1: go to HOLDOFF, increment DROP_CNT (saturates at 65535), START_TRG stays 0.
  - ARMED with TRG_ENABLE=0: stay in ARMED; hits are ignored.
  - ACQ: START_TRG=1; the counter decrements every cycle. At count 1 -> HOLDOFF.
- Events inside ACQ:
  - Hits are ignored.
  - FIFO_FULL and TRG_ENABLE changes do not abort the window.
- A second window requires HOLDOFF to see hit_r=0. Result: START_TRG is low for at least 1 cycle between windows, and a sustained over-threshold signal yields exactly one window.

## Timing
- Crossing beat accepted at cycle c:
  - hit_r is high at c+1.
  - START_TRG is high for cycles c+2 .. c+1+PRE_ACQUI_LEN+POST_ACQUI_LEN (50 cycles at default).
  - TIME_STAMP changes at c+2 to the counter value of cycle c.
- The first M_AXIS_TDATA beat in the window is the input from cycle c-PRE_ACQUI_LEN. The last is from c+POST_ACQUI_LEN-1.
- Reset values: START_TRG 0, TIME_STAMP 0, DROP_CNT 0, S_AXIS_TREADY 0, M_AXIS_TVALID 0, M_AXIS_TDATA 0, counter 0, state FILL.
- Reset asserted mid-window: all outputs go to reset values immediately (asynchronous). After release, the block refills for PRE_ACQUI_LEN+2 cycles before it can arm.
- A hit on the cycle FSM enters ARMED is only taken if hit_r=0 was seen in HOLDOFF. A hit_r=1 arriving the cycle after that triggers.

## Test plan
- Reset; zero data; cycle 100 lane 3 sample = 300, timestamp counter = 100 -> START_TRG high cycles 102..151, TIME_STAMP=100, M_AXIS_TDATA at cycle 102 equals input of cycle 88.
- Sample = 204 -> no trigger. Sample = 205 -> trigger. Sample = -300 -> no trigger.
- Over-threshold held 80 cycles -> exactly one 50-cycle window. Then one quiet cycle plus a new hit -> second window, with START_TRG low for ≥1 cycle between the windows.
- FIFO_FULL=1 at a hit -> START_TRG stays 0, DROP_CNT=1. Preload 65535 drops -> DROP_CNT stays 65535. FIFO_FULL rising mid-window -> window completes with full length.
- Hit at cycle 5 after reset release -> ignored. TRG_ENABLE=0 hit -> ignored. Crossing with counter at 65535 -> TIME_STAMP=65535, and the counter reads 0 next cycle.
- AXIS_ARESET pulsed at cycle 20 of a window -> START_TRG, TIME_STAMP and DROP_CNT are 0 within the same cycle. A hit 5 cycles after release -> ignored.
